spike_detector: RTL
===================

Name: spike_detector

Overview:
- Consumes the 16-bit offset-binary sample stream produced by the front-end ADC / mock-ADC stage, one sample per `sample_valid`.
- Removes the slow LFP baseline with a high-pass EMA and calibrates a noise-scaled negative threshold.
- Detects negative-going spikes and emits one event record per spike: timestamp, peak, width.
- Events are offered on a valid/ready interface to the downstream sorting/packetising stage.

Parameters:
- HP_SHIFT, 6: baseline EMA time constant, 2^HP_SHIFT samples.
- CAL_LOG2, 10: calibration length is 2^CAL_LOG2 valid samples.
- THR_MULT, 4: threshold = THR_MULT × mean |hp|; range 1..15.
- THR_MIN, 64: minimum threshold magnitude.
- REFRACT, 32: dead time after an event, in valid samples; must be ≥ 1.
- TS_W, 32: timestamp width.
- NOISE_SHIFT, 10: adaptive noise EMA shift; used only with ADAPTIVE_THR_EN.

Ports:
- clk  in  1  — system clock.
- rst  in  1  — synchronous, active-high reset.
- sample_in  in  16  — offset-binary ADC sample; bit15 inverted relative to two's complement.
- sample_valid  in  1  — sample_in is valid this cycle.
- ev_valid  out  1  — event record is available.
- ev_ready  in  1  — downstream accepts the event.
- ev_timestamp  out  TS_W  — sample index of the first below-threshold sample.
- ev_peak  out  16  — most negative hp value during the spike, signed.
- ev_width  out  8  — number of consecutive below-threshold samples, saturating at 255.
- threshold_out  out  16  — current threshold, signed, ≤ 0.
- calibrated  out  1  — high once calibration is complete.
- ev_overflow  out  1  — sticky flag: an event was dropped.

Behaviour:
- **Reset values.** On rst: all outputs 0; state CAL; baseline accumulator, calibration sum, timestamp counter and refractory counter all 0. rst mid-spike discards the spike and any pending event, then calibration restarts.
- **Stall.** No state, counter or accumulator advances on cycles where sample_valid is 0.
- **Stage 1 (registered on sample_valid).**
  - Convert: s = {~sample_in[15], sample_in[14:0]}, signed.
  - Baseline: acc (signed, 16+HP_SHIFT bits) updates as acc <= acc + s - (acc >>> HP_SHIFT); baseline = acc >>> HP_SHIFT.
  - High-pass: hp = s - baseline, computed in 17 bits and saturated to [-32768, 32767].
  - ts_cnt increments once per valid sample and wraps modulo 2^TS_W; the sample carries its pre-increment value.
- **Stage 2 (FSM).** Acts on stage-1 output when stage-1 valid is set.
  - **CAL:** add |hp| (|-32768| = 32768) into a (17+CAL_LOG2)-bit sum. After 2^CAL_LOG2 samples:
    - m = sum >> CAL_LOG2;
    - mag = max(THR_MULT × m, THR_MIN), saturated to 32768;
    - threshold = -mag;
    - calibrated <= 1; go to ARMED.
    - No detection occurs in CAL.
  - **ARMED:** if hp < threshold (strict), latch ts, peak = hp, width = 1; go to SPIKE.
  - **SPIKE:** while hp < threshold, width += 1 (saturating at 255) and peak = min(peak, hp). On the first hp ≥ threshold:
    - emit the event (this sample is not counted in width);
    - load refr = REFRACT; go to REFRACT.
  - **REFRACT:** decrement refr per valid sample; on the sample where refr reaches 0, go to ARMED. That sample is not tested, so testing resumes REFRACT+1 samples after the emitting sample.
- **Output handshake (one-entry register).**
  - An emitted event loads ev_* and sets ev_valid at the same clock edge as the FSM transition.
  - ev_valid and the ev_* fields are held stable until a cycle with ev_valid & ev_ready, which clears ev_valid.
  - Emit while ev_valid & !ev_ready: the new event is dropped, ev_overflow is set (cleared only by rst), and the FSM still enters REFRACT.
  - Emit in the same cycle as an accepting handshake: the new event loads; ev_valid stays 1.
- **Latency.** ev_valid rises 2 clk after the sample_valid cycle of the terminating (first ≥ threshold) sample, given back-to-back clocks.

Optional Feature:
- **Macro ADAPTIVE_THR_EN.**
- **When defined:** in ARMED only, a noise EMA n tracks |hp|: n_acc <= n_acc + |hp| - (n_acc >> NOISE_SHIFT); n = n_acc >> NOISE_SHIFT.
  - n_acc is seeded with m << NOISE_SHIFT at the end of CAL.
  - threshold is recomputed each ARMED sample as -max(THR_MULT × n, THR_MIN).
  - The threshold is frozen in SPIKE and REFRACT.
- **When undefined:** the threshold is fixed from CAL until rst, and no n_acc logic is instantiated.

Test Plan:
- **Calibration.** CAL_LOG2=4, HP_SHIFT=12, THR_MULT=4; drive 16 samples alternating 0x8064 / 0x7F9C (±100) → calibrated=1 after the 16th sample; threshold_out within -400±8.
- **Single spike.** After calibration drive ±100 noise, then 3 samples of 0x7830 (-2000), then 0x8000 → ev_valid once; ev_width=3; ev_peak=-2000±8; ev_timestamp = index of the first -2000 sample.
- **Refractory.** REFRACT=32; a second 1-sample -2000 spike 10 samples after the first event → no event. The same spike placed 40 samples after the first event → event with width 1.
- **Backpressure.** Hold ev_ready=0 across two spikes separated by more than REFRACT → first event stays stable; second is dropped; ev_overflow=1. ev_ready=1 → ev_valid clears; no second event appears.
- **Stall / saturation / reset.** sample_valid gaps of 3 cycles inside a spike → same width and timestamp as the gap-free run. A 300-sample spike → ev_width=255. rst asserted mid-spike → no event emitted; calibrated=0.
- **Adaptive threshold (ADAPTIVE_THR_EN defined, NOISE_SHIFT=4).** Raise noise to ±300 → threshold_out converges to -1200±32 within 200 samples. Without the macro, threshold_out stays at -400±8.

Source files
------------

// File: rtl/spike_detector.sv
// spike_detector: high-pass EMA baseline removal, noise-calibrated negative threshold, one event per spike.
// Latency: an event appears 2 clk after the valid cycle of the sample that ends the spike (stage 1 + FSM).
// Backpressure: one-entry output register; an event emitted while the register is full and not being
//               accepted is dropped and sets the sticky ev_overflow flag. The sample input is never stalled.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   sample_in/_valid    16-bit offset-binary ADC sample stream
//   ev_valid/ev_ready   event handshake; ev_timestamp, ev_peak, ev_width carry the record
//   threshold_out       current signed threshold (<= 0), 0 until calibration completes
//   calibrated          high once the calibration window has been consumed
//   ev_overflow         sticky: an event was dropped because the output register was still full
//
// Optional feature: define ADAPTIVE_THR_EN to track the noise level with an EMA while armed and
// recompute the threshold every armed sample; without it the threshold is fixed after calibration.

module spike_detector #(
  parameter int HP_SHIFT    = 6,
  parameter int CAL_LOG2    = 10,
  parameter int THR_MULT    = 4,
  parameter int THR_MIN     = 64,
  parameter int REFRACT     = 32,
  parameter int TS_W        = 32,
  parameter int NOISE_SHIFT = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            sample_in,
  input  logic                   sample_valid,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [TS_W-1:0]        ev_timestamp,
  output logic signed [15:0]     ev_peak,
  output logic [7:0]             ev_width,
  output logic signed [15:0]     threshold_out,
  output logic                   calibrated,
  output logic                   ev_overflow
);

  localparam logic [1:0] ST_CAL   = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SPIKE = 2'd2;
  localparam logic [1:0] ST_REFR  = 2'd3;

  localparam int AW = 16 + HP_SHIFT;          // baseline accumulator width
  localparam int SW = 17 + CAL_LOG2;          // calibration sum width
  localparam int RW = $clog2(REFRACT + 1);    // refractory counter width

  if (REFRACT < 1 || THR_MULT < 1 || THR_MULT > 15 || NOISE_SHIFT < 1 ||
      HP_SHIFT < 1 || CAL_LOG2 < 1) begin : g_param_check
    $error("spike_detector: parameter out of range");
  end

  // Threshold from a mean-magnitude estimate: -min(max(THR_MULT*m, THR_MIN), 32768).
  // -32768 is the only magnitude that does not fit positive 16-bit, hence the 17-bit negate.
  function automatic logic signed [15:0] thr_calc(input logic [16:0] m);
    logic [20:0] prod;
    logic [20:0] mag;
    logic [16:0] neg;
    prod = 21'(m) * 21'(THR_MULT);
    mag  = (prod < 21'(THR_MIN)) ? 21'(THR_MIN) : prod;
    if (mag > 21'd32768) mag = 21'd32768;
    neg = 17'd0 - mag[16:0];
    return neg[15:0];
  endfunction

  // ------------------------------------------------------------------
  // Stage 1: offset-binary conversion, baseline EMA, saturated high-pass
  // ------------------------------------------------------------------
  logic signed [15:0]   s_cur;
  logic signed [AW-1:0] s_ext;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sh;
  logic signed [AW-1:0] acc_nxt;
  logic signed [15:0]   baseline;
  logic signed [16:0]   hp_wide;
  logic signed [15:0]   hp_sat;

  logic                 s1_vld;
  logic signed [15:0]   s1_hp;
  logic [TS_W-1:0]      s1_ts;
  logic [TS_W-1:0]      ts_cnt;

  assign s_cur    = {~sample_in[15], sample_in[14:0]};
  assign s_ext    = AW'(s_cur);
  assign acc_sh   = acc >>> HP_SHIFT;
  // acc stays within +/-2^(15+HP_SHIFT), so the shifted value always fits 16 bits.
  assign baseline = acc_sh[15:0];
  assign acc_nxt  = acc + s_ext - acc_sh;
  assign hp_wide  = 17'(s_cur) - 17'(baseline);

  always_comb begin
    hp_sat = hp_wide[15:0];
    if (hp_wide[16] != hp_wide[15]) begin
      hp_sat = hp_wide[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      ts_cnt <= '0;
      s1_vld <= 1'b0;
      s1_hp  <= '0;
      s1_ts  <= '0;
    end else begin
      // s1_vld follows sample_valid so each valid sample is seen by the FSM exactly once.
      s1_vld <= sample_valid;
      if (sample_valid) begin
        acc    <= acc_nxt;
        s1_hp  <= hp_sat;
        s1_ts  <= ts_cnt;
        ts_cnt <= ts_cnt + TS_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: calibration / detection FSM
  // ------------------------------------------------------------------
  logic [1:0]          state;
  logic [SW-1:0]       cal_sum;
  logic [SW-1:0]       cal_total;
  logic [CAL_LOG2-1:0] cal_cnt;
  logic                cal_last;
  logic [16:0]         cal_m;
  logic signed [16:0]  hp17;
  logic [16:0]         abs_hp;
  logic                below;
  logic                emit;
  logic [TS_W-1:0]     sp_ts;
  logic signed [15:0]  sp_peak;
  logic [7:0]          sp_width;
  logic [7:0]          width_inc;
  logic [RW-1:0]       refr_cnt;

  assign hp17      = 17'(s1_hp);
  assign abs_hp    = hp17[16] ? 17'(-hp17) : 17'(hp17);
  assign cal_total = cal_sum + SW'(abs_hp);
  assign cal_last  = (cal_cnt == '1);
  assign cal_m     = cal_total[SW-1:CAL_LOG2];
  assign below     = (s1_hp < threshold_out);
  assign width_inc = (sp_width == 8'hFF) ? 8'hFF : sp_width + 8'd1;
  // The first at-or-above-threshold sample in SPIKE closes the spike.
  assign emit      = s1_vld && (state == ST_SPIKE) && !below;

`ifdef ADAPTIVE_THR_EN
  localparam int NW = 17 + NOISE_SHIFT;
  logic [NW-1:0] n_acc;
  logic [NW-1:0] n_nxt;
  logic [16:0]   n_new;

  assign n_nxt = n_acc + NW'(abs_hp) - (n_acc >> NOISE_SHIFT);
  assign n_new = n_nxt[NW-1:NOISE_SHIFT];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_CAL;
      cal_sum       <= '0;
      cal_cnt       <= '0;
      threshold_out <= '0;
      calibrated    <= 1'b0;
      sp_ts         <= '0;
      sp_peak       <= '0;
      sp_width      <= '0;
      refr_cnt      <= '0;
`ifdef ADAPTIVE_THR_EN
      n_acc         <= '0;
`endif
    end else if (s1_vld) begin
      case (state)
        ST_CAL: begin
          cal_sum <= cal_total;
          cal_cnt <= cal_cnt + CAL_LOG2'(1);
          if (cal_last) begin
            threshold_out <= thr_calc(cal_m);
            calibrated    <= 1'b1;
            state         <= ST_ARMED;
`ifdef ADAPTIVE_THR_EN
            n_acc         <= NW'(cal_m) << NOISE_SHIFT;
`endif
          end
        end
        ST_ARMED: begin
          // Detection compares against the threshold in force before this sample.
          if (below) begin
            sp_ts    <= s1_ts;
            sp_peak  <= s1_hp;
            sp_width <= 8'd1;
            state    <= ST_SPIKE;
          end
`ifdef ADAPTIVE_THR_EN
          n_acc         <= n_nxt;
          threshold_out <= thr_calc(n_new);
`endif
        end
        ST_SPIKE: begin
          if (below) begin
            sp_width <= width_inc;
            if (s1_hp < sp_peak) sp_peak <= s1_hp;
          end else begin
            refr_cnt <= RW'(REFRACT);
            state    <= ST_REFR;
          end
        end
        ST_REFR: begin
          // The sample that brings the count to zero is consumed without testing.
          refr_cnt <= refr_cnt - RW'(1);
          if (refr_cnt == RW'(1)) state <= ST_ARMED;
        end
        default: state <= ST_CAL;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // One-entry output register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid     <= 1'b0;
      ev_timestamp <= '0;
      ev_peak      <= '0;
      ev_width     <= '0;
      ev_overflow  <= 1'b0;
    end else begin
      if (ev_valid && ev_ready) ev_valid <= 1'b0;
      if (emit) begin
        // A slot being accepted this cycle counts as free.
        if (!ev_valid || ev_ready) begin
          ev_valid     <= 1'b1;
          ev_timestamp <= sp_ts;
          ev_peak      <= sp_peak;
          ev_width     <= sp_width;
        end else begin
          ev_overflow  <= 1'b1;
        end
      end
    end
  end

endmodule
